// File: rtl/ysyx_23060203_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, FSM states,
// and operand signedness decode.
package ysyx_23060203_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } mdu_state_e;

    // rs1 is signed for everything except the fully unsigned ops.
    function automatic logic op_a_signed(input logic [2:0] funct);
        return (funct != MDU_MULHU) && (funct != MDU_DIVU) && (funct != MDU_REMU);
    endfunction

    // rs2 is signed only for MUL/MULH/DIV/REM.
    function automatic logic op_b_signed(input logic [2:0] funct);
        return (funct == MDU_MUL) || (funct == MDU_MULH) ||
               (funct == MDU_DIV) || (funct == MDU_REM);
    endfunction

endpackage

// File: rtl/ysyx_23060203_mdu_negate.sv
// Conditional two's-complement negator, used for operand magnitudes and result fixup.
module ysyx_23060203_mdu_negate #(
    parameter int unsigned Width = 32
) (
    input  logic             neg_i,
    input  logic [Width-1:0] val_i,
    output logic [Width-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + Width'(1)) : val_i;

endmodule

// File: rtl/ysyx_23060203_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// valid/ready on both sides, flush aborts in-flight work.
module ysyx_23060203_mdu
    import ysyx_23060203_mdu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [2:0]   in_funct,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_val
);

    localparam int unsigned CntW = $clog2(W) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    mdu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // Multiplicand |a| for MUL, divisor |b| for DIV.
    logic [W-1:0]    opa_q, opa_d;
    // MUL: {partial high, remaining multiplier bits}. DIV: {remainder, dividend/quotient}.
    logic [2*W-1:0]  acc_q, acc_d;
    logic            sign_q, sign_d;
    // MUL: return high half. DIV: return remainder.
    logic            sel_hi_q, sel_hi_d;
    logic [W-1:0]    out_val_q, out_val_d;

    // Accept-time decode
    logic         a_neg, b_neg, is_div, div_by_zero, div_ovf;
    logic [W-1:0] a_mag, b_mag;

    assign a_neg       = op_a_signed(in_funct) & in_a[W-1];
    assign b_neg       = op_b_signed(in_funct) & in_b[W-1];
    assign is_div      = in_funct[2];
    assign div_by_zero = is_div && (in_b == '0);
    assign div_ovf     = is_div && !in_funct[0] && (in_a == {1'b1, {(W-1){1'b0}}}) &&
                         (in_b == '1);

    ysyx_23060203_mdu_negate #(.Width(W)) u_neg_a (
        .neg_i (a_neg),
        .val_i (in_a),
        .val_o (a_mag)
    );

    ysyx_23060203_mdu_negate #(.Width(W)) u_neg_b (
        .neg_i (b_neg),
        .val_i (in_b),
        .val_o (b_mag)
    );

    // One shift-add step
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // One restoring-division step; the shifted remainder needs one guard bit.
    logic [W:0]     div_shift, div_diff;
    logic           div_bit;
    logic [W-1:0]   div_rem, div_quo;

    assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_diff  = div_shift - {1'b0, opa_q};
    assign div_bit   = ~div_diff[W];
    assign div_rem   = div_bit ? div_diff[W-1:0] : div_shift[W-1:0];
    assign div_quo   = {acc_q[W-2:0], div_bit};

    // Sign fixup folded into the final iteration so DONE needs no extra cycle.
    logic [2*W-1:0] fix_in, fix_out;
    logic [W-1:0]   result;

    assign fix_in = (state_q == StMul) ? mul_next :
                    {{W{1'b0}}, (sel_hi_q ? div_rem : div_quo)};

    ysyx_23060203_mdu_negate #(.Width(2 * W)) u_neg_fix (
        .neg_i (sign_q),
        .val_i (fix_in),
        .val_o (fix_out)
    );

    assign result = ((state_q == StMul) && sel_hi_q) ? fix_out[2*W-1:W] : fix_out[W-1:0];

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        acc_d     = acc_q;
        sign_d    = sign_q;
        sel_hi_d  = sel_hi_q;
        out_val_d = out_val_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    cnt_d    = '0;
                    sign_d   = (is_div && in_funct[1]) ? a_neg : (a_neg ^ b_neg);
                    sel_hi_d = is_div ? in_funct[1] : (in_funct != MDU_MUL);
                    if (div_by_zero) begin
                        out_val_d = in_funct[1] ? in_a : '1;
                        state_d   = StDone;
                    end else if (div_ovf) begin
                        out_val_d = in_funct[1] ? '0 : in_a;
                        state_d   = StDone;
                    end else if (is_div) begin
                        opa_d   = b_mag;
                        acc_d   = {{W{1'b0}}, a_mag};
                        state_d = StDiv;
                    end else begin
                        opa_d   = a_mag;
                        acc_d   = {{W{1'b0}}, b_mag};
                        state_d = StMul;
                    end
                end
            end
            StMul, StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = (state_q == StMul) ? mul_next : {div_rem, div_quo};
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        out_val_d = result;
                        state_d   = StDone;
                    end
                end
            end
            StDone: begin
                if (flush || out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            opa_q     <= '0;
            acc_q     <= '0;
            sign_q    <= 1'b0;
            sel_hi_q  <= 1'b0;
            out_val_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            acc_q     <= acc_d;
            sign_q    <= sign_d;
            sel_hi_q  <= sel_hi_d;
            out_val_q <= out_val_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_val   = out_val_q;

endmodule

// File: tb/tb_ysyx_23060203_mdu.sv
// Directed self-checking bench for the RV32M multiply/divide unit.
module tb_ysyx_23060203_mdu;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    // Result visible in the cycle after accept for special cases, W cycles later otherwise.
    localparam int LatNorm = 33;
    localparam int LatSpec = 1;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_funct;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_val;

    int compared;
    int mismatched;
    logic seen;

    ysyx_23060203_mdu #(.W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_funct  (in_funct),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_val   (out_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Present an op for one edge; returns at the negedge after the accept edge.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_funct = f;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid; checks latency (cycles after accept) and value.
    task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp);
        int cyc;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk(tag, out_val, exp);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hs_in_ready", {31'b0, in_ready}, 32'd1);
        chk("hs_out_valid", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        start_op(f, a, b);
        wait_result(tag, lat, exp);
        handshake();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_funct   = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;

        #23;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_val", out_val, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiply
        run("mul_7_m3",      F_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, LatNorm);
        run("mulh_7_m3",     F_MULH,   32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, LatNorm);
        run("mulhu_ff_ff",   F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LatNorm);
        run("mulhsu_ff_ff",  F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LatNorm);
        run("mul_zero",      F_MUL,    32'h00000000, 32'h12345678, 32'h00000000, LatNorm);
        run("mul_big",       F_MUL,    32'h00012345, 32'h00010000, 32'h23450000, LatNorm);

        // Divide
        run("div_m7_2",      F_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, LatNorm);
        run("rem_m7_2",      F_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, LatNorm);
        run("divu_80_3",     F_DIVU,   32'h80000000, 32'h00000003, 32'h2AAAAAAA, LatNorm);
        run("remu_80_3",     F_REMU,   32'h80000000, 32'h00000003, 32'h00000002, LatNorm);
        run("rem_7_m2",      F_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, LatNorm);

        // Special cases resolved at accept
        run("div_by_zero",   F_DIV,    32'h12345678, 32'h00000000, 32'hFFFFFFFF, LatSpec);
        run("rem_by_zero",   F_REM,    32'h12345678, 32'h00000000, 32'h12345678, LatSpec);
        run("divu_by_zero",  F_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, LatSpec);
        run("remu_by_zero",  F_REMU,   32'h00000005, 32'h00000000, 32'h00000005, LatSpec);
        run("div_ovf",       F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LatSpec);
        run("rem_ovf",       F_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, LatSpec);

        // Output stall: value held, no acceptance
        start_op(F_MUL, 32'h00000007, 32'hFFFFFFFD);
        wait_result("stall_mul", LatNorm, 32'hFFFFFFEB);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_out_val", out_val, 32'hFFFFFFEB);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        // Handshake with a new op already presented: it must not be taken this cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_funct  = F_DIVU;
        in_a      = 32'd100;
        in_b      = 32'd7;
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_in_ready_after_hs", {31'b0, in_ready}, 32'd1);
        chk("b2b_out_valid_after_hs", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_accepted", {31'b0, in_ready}, 32'd0);
        wait_result("b2b_divu", LatNorm, 32'd14);
        handshake();

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        in_funct = F_MUL;
        in_a     = 32'd3;
        in_b     = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_idle_in_ready", {31'b0, in_ready}, 32'd1);

        // Flush around iteration 10 of DIV
        start_op(F_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_div_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_div_out_valid", {31'b0, out_valid}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_div_no_result", {31'b0, seen}, 32'd0);

        // Flush in DONE discards the result
        start_op(F_DIV, 32'd5, 32'd0);
        chk("flush_done_valid", {31'b0, out_valid}, 32'd1);
        chk("flush_done_val", out_val, 32'hFFFFFFFF);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_done_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_done_in_ready", {31'b0, in_ready}, 32'd1);

        // Asynchronous reset mid-MUL
        start_op(F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_out_val", out_val, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst_mul", F_MUL, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, LatNorm);
        run("post_rst_divu", F_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, LatNorm);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_mdu.md
Name: ysyx_23060203_mdu

Overview:
- Iterative multiply/divide unit for the RV32M instructions. It sits next to the combinational ALU in the EXU.
- The ALU covers single-cycle RV32I arithmetic. This block covers the multi-cycle M-extension operations.
- Operands come in and results go out over valid/ready handshakes, so the EXU can stall while the unit is busy.
- A flush input discards in-flight work on redirect.

Parameters:
- W, 32, operand/result width; iteration count equals W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  unit idle, can accept
- in_a  in  W  rs1 value
- in_b  in  W  rs2 value
- in_funct  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- flush  in  1  abort current operation
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_val  out  W  result

Behaviour:
- Clock and reset: one clock (clk). Reset (rst_n) is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_val=0, all internal registers 0.
- FSM states and transitions:
  - IDLE -> MUL or DIV on in_valid&in_ready.
  - MUL/DIV -> DONE after W iterations.
  - DONE -> IDLE on out_valid&out_ready.
- in_ready=1 only in IDLE. out_valid=1 only in DONE. out_val is held stable while out_valid=1 and out_ready=0.
- Accept (edge T) latches:
  - operand magnitudes: |a| if a is treated signed and negative, else a; same for b;
  - result sign flag;
  - which half/quotient/remainder to select;
  - counter=0.
- Signedness: MUL/MULH/DIV/REM treat a and b as signed. MULHSU treats a signed, b unsigned. MULHU/DIVU/REMU treat both unsigned.
- MUL state: radix-2 shift-add on a 2W-bit product register, one bit of |b| per cycle.
  - After W cycles, negate the 2W-bit product if the sign flag is set.
  - MUL returns the low W bits; MULH/MULHSU/MULHU return the high W bits.
- DIV state: restoring division, one quotient bit per cycle, W-bit remainder plus one guard bit.
  - Quotient sign = sign(a)^sign(b). Remainder sign = sign(a).
- Fixup (negation) happens on the transition into DONE, not as an extra cycle.
- Latency for normal operations: result registered at T+W+1; out_valid high in cycle T+W+1 (33 cycles for W=32).
- Special cases are resolved at accept and go straight to DONE, so out_valid is high at T+1:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): DIV returns 0x80000000, REM returns 0.
  - Multiply with an operand of 0 still takes the full W cycles (no early-out).
- flush:
  - In MUL, DIV or DONE, flush returns the FSM to IDLE next edge; out_valid drops and the result is discarded.
  - In IDLE, flush blocks acceptance that cycle (flush wins over in_valid).
- Back-to-back: a new op can be accepted only in the cycle after the DONE handshake (in_ready returns to 1 in IDLE). There is no acceptance in the same cycle as out handshake.
- Asynchronous reset mid-operation: immediate return to IDLE, outputs at reset values, no result is emitted.
- Counter width: clog2(W)+1. Compare against W-1 to end the iteration.

Decomposition:
- Shared package (params/mdu.v, alongside params/alu.v): funct3 localparams MDU_MUL..MDU_REMU, FSM state encodings.
- One sub-module is natural: ysyx_23060203_mdu_negate, a W-bit or 2W-bit conditional two's-complement negator. It is reused for operand magnitude and result fixup.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> out_val=0xFFFFFFEB, out_valid at T+33; MULH same operands -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0x80000000/3 -> 0x2AAAAAAA; REMU -> 0x00000002.
- DIV x/0 with a=0x12345678 -> 0xFFFFFFFF at T+1; REM -> 0x12345678; DIV 0x80000000/-1 -> 0x80000000; REM -> 0 at T+1.
- out_ready held low 5 cycles after DONE -> out_val stable, in_ready=0; then handshake -> in_ready=1 next cycle and a new op is accepted.
- flush at iteration 10 of DIV -> IDLE next edge, no out_valid; rst_n pulse mid-MUL -> immediate reset values, following op computes correctly.
